affine_ctrl_vars_gen: RTL
=========================

# affine_ctrl_vars_gen

Schedule-driven loop-nest controller that drives one port of a unified buffer (`*_ub`). It counts an affine iteration domain of up to NUM_DIMS loops. For each iteration it emits `ctrl_vars` together with a one-cycle `valid` strobe, used as the buffer's `*_wen` or `*_ren`, at the statically scheduled cycle `offset + Σ idx[k]*cycle_stride[k]`. One instance sits beside every buffer read or write port. It is the producer of the control vectors that the buffers consume.

## Interface
Parameters:
- NUM_DIMS, 4, loop depth. Index 0 is outermost/root; NUM_DIMS-1 is innermost.
- CTRL_W, 16, width of each index and each extent.
- TIME_W, 32, width of the cycle counter, offset and strides.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-high. One clock domain.
- flush  in  1  synchronous restart to IDLE. Identical to `rst` except that latched config is retained.
- start  in  1  launch pulse. Sampled only in IDLE or DONE.
- stall  in  1  freezes all state while high.
- cfg_extent  in  CTRL_W×NUM_DIMS  trip count per dimension.
- cfg_cycle_stride  in  TIME_W×NUM_DIMS  schedule coefficient per dimension.
- cfg_offset  in  TIME_W  schedule constant.
- valid  out  1  fire strobe; connects to `*_wen`/`*_ren`.
- ctrl_vars  out  CTRL_W×NUM_DIMS  current iteration indices.
- busy  out  1  high in DELAY or RUN.
- done  out  1  one-cycle pulse after the last fire.
- err  out  1  sticky schedule-violation flag.

## Operation
- States:
  - IDLE → (start) → DELAY.
  - DELAY → (cycle==fire_time) → RUN.
  - RUN → (last fire) → DONE.
  - DONE → IDLE after one cycle.
  - DONE → DELAY if `start` is high in DONE.
- On the `start` edge:
  - Latch all `cfg_*`.
  - Clear the indices and the cycle counter.
  - Set fire_time = cfg_offset.
- The cycle counter increments every non-stalled cycle while busy.
- `valid` = busy && !stall && cycle==fire_time. `ctrl_vars` holds the indices of the firing iteration.
- On a fire:
  - Increment the innermost index with carry outward. A dimension that reaches extent−1 wraps to 0 and carries.
  - Recompute fire_time = offset + Σ idx[k]*stride[k] incrementally, with no multipliers. Keep a per-dimension partial sum: add the stride on increment, clear it on wrap.
- Last fire: every index equals extent−1. That fire is followed by `done` in the next cycle.
- Empty domain (any extent==0): go `start` → DONE with no `valid`; `done` pulses the cycle after `start`.
- Error: a recomputed fire_time ≤ the current cycle means the schedule is non-monotonic.
  - Set `err` (sticky until `rst`/`flush`).
  - Continue by firing the next iteration in the next cycle.
- `start` while busy is ignored.
- Arithmetic is modulo 2^TIME_W. The schedule must not wrap.

## Timing
- Reset values:
  - `valid`=0, `busy`=0, `done`=0, `err`=0.
  - `ctrl_vars`=0.
  - State = IDLE.
  - Config registers = 0.
- `rst` or `flush` mid-run takes effect at the next edge. No further `valid`; no `done`.
- Cycle 0 is the cycle after the `start` edge. First `valid` appears at cycle cfg_offset, so the minimum latency is 1 cycle.
- Outputs are registered state decoded combinationally. `ctrl_vars` is stable for the whole `valid` cycle.
- `stall` high: `valid` is forced 0 and the counter, indices and state hold. All fire times slip by the number of stalled cycles.
- Back-to-back fires are allowed when the stride is 1 (one fire per cycle).

## Configuration
- `AFFINE_CTRL_ERR_EN` defined: the violation detector and `err` are built.
- Undefined: `err` is tied 0 and no comparator is built. A violating schedule then stalls until wrap; this is the user's responsibility.

## Structure
- Package `affine_ctrl_pkg` holds:
  - the state enum;
  - default CTRL_W/TIME_W constants;
  - packed typedefs for the index and time vectors.
- Sub-module `affine_dim_counter`, one per dimension. Each instance has:
  - its index register and partial-time register;
  - wrap/carry in and carry out;
  - a stride add.
- The top module holds the FSM, the cycle counter and the sum tree.

## Test plan
- Single dim: extent 3, stride 2, offset 5 → `valid` at cycles 5, 7, 9 with idx 0, 1, 2; `done` at cycle 10.
- Nest {1,4,32,32} with strides {0,1024,32,1} and offset 0 → 4096 consecutive fires; `ctrl_vars` sequence matches a golden loop nest; `done` at cycle 4096.
- Stall held 3 cycles at cycle 6 of the first test → fires at 5, 10, 12 instead of 5, 7, 9.
- Extent {1,1,0,8} → no `valid`; `done` one cycle after `start`.
- Stride {0,0,1,1} with extents {1,1,2,4} → `err` set on the outer carry when `AFFINE_CTRL_ERR_EN` is defined, and 0 without it.
- `flush` at cycle 20 of the second test → `valid` stops immediately. A new `start` replays from idx 0 using the retained config.

Source files
------------

// File: rtl/affine_ctrl_pkg.sv
// Shared types and defaults for the affine loop-nest controller.
// Optional feature macro: AFFINE_CTRL_ERR_EN (schedule-violation detector).
package affine_ctrl_pkg;

  localparam int NUM_DIMS_DEF = 4;
  localparam int CTRL_W_DEF   = 16;
  localparam int TIME_W_DEF   = 32;

  // Index 0 is the outermost loop, NUM_DIMS_DEF-1 the innermost.
  typedef logic [NUM_DIMS_DEF-1:0][CTRL_W_DEF-1:0] idx_vec_t;
  typedef logic [NUM_DIMS_DEF-1:0][TIME_W_DEF-1:0] time_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/affine_dim_counter.sv
// One loop dimension: iteration index plus its contribution idx*stride to the
// schedule, maintained incrementally. The top decides when this dimension
// steps (carry in); at_max tells the top this step wraps and carries outward.
// Optional feature macro (handled in top): AFFINE_CTRL_ERR_EN.
module affine_dim_counter
  import affine_ctrl_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [CTRL_W-1:0] extent,
  input  logic [TIME_W-1:0] stride,
  output logic [CTRL_W-1:0] idx,
  output logic [TIME_W-1:0] part_next,
  output logic              at_max
);

  logic [TIME_W-1:0] part_q;

  assign at_max = (idx == extent - CTRL_W'(1));

  // Partial time after this cycle: add stride on a plain step, clear on wrap.
  always_comb begin
    // NOTE: assigning a default first keeps this purely combinational (no latch).
    part_next = part_q;
    if (inc) begin
      part_next = at_max ? '0 : part_q + stride;
    end
  end

  // Index and partial-time registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst || clr) begin
      idx    <= '0;
      part_q <= '0;
    end else if (inc) begin
      idx    <= at_max ? '0 : idx + CTRL_W'(1);
      part_q <= part_next;
    end
  end

endmodule

// File: rtl/affine_ctrl_vars_gen.sv
// Schedule-driven loop-nest controller for one unified-buffer port. Emits
// ctrl_vars with a one-cycle valid at cycle offset + sum(idx[k]*stride[k]).
// Optional feature macro: AFFINE_CTRL_ERR_EN builds the non-monotonic
// schedule detector and the sticky err flag; otherwise err is tied low.
module affine_ctrl_vars_gen
  import affine_ctrl_pkg::*;
#(
  parameter int NUM_DIMS = NUM_DIMS_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int TIME_W   = TIME_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           start,
  input  logic                           stall,
  input  logic [NUM_DIMS-1:0][CTRL_W-1:0] cfg_extent,
  input  logic [NUM_DIMS-1:0][TIME_W-1:0] cfg_cycle_stride,
  input  logic [TIME_W-1:0]              cfg_offset,
  output logic                           valid,
  output logic [NUM_DIMS-1:0][CTRL_W-1:0] ctrl_vars,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  state_t state_q, state_d;

  logic [NUM_DIMS-1:0][CTRL_W-1:0] extent_q;
  logic [NUM_DIMS-1:0][TIME_W-1:0] stride_q;
  logic [TIME_W-1:0]               offset_q;
  logic [TIME_W-1:0]               cycle_q;
  logic [TIME_W-1:0]               fire_time_q;

  logic                            fire;
  logic                            load;
  logic                            clr;
  logic                            empty;
  logic                            last;
  logic                            carry;
  logic [NUM_DIMS-1:0]             inc;
  logic [NUM_DIMS-1:0]             at_max;
  logic [NUM_DIMS-1:0][TIME_W-1:0] part_next;
  logic [TIME_W-1:0]               next_fire_time;
  logic [TIME_W-1:0]               fire_time_sel;

  assign busy  = (state_q == ST_DELAY) || (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign fire  = busy && !stall && (cycle_q == fire_time_q);
  assign valid = fire;
  assign load  = start && !stall && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign clr   = flush || load;

  // Any zero trip count means the domain is empty; checked on the live inputs
  // because they are being latched on the same edge.
  always_comb begin
    empty = 1'b0;
    for (int k = 0; k < NUM_DIMS; k++) begin
      if (cfg_extent[k] == '0) empty = 1'b1;
    end
  end

  // Carry chain from innermost outward: a dimension steps when every inner
  // dimension wraps on this fire. A carry out of dimension 0 is the last fire.
  always_comb begin
    carry = fire;
    inc   = '0;
    for (int k = NUM_DIMS - 1; k >= 0; k--) begin
      inc[k] = carry;
      carry  = carry && at_max[k];
    end
    last = carry;
  end

  for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
    affine_dim_counter #(
      .CTRL_W (CTRL_W),
      .TIME_W (TIME_W)
    ) u_dim (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .inc       (inc[k]),
      .extent    (extent_q[k]),
      .stride    (stride_q[k]),
      .idx       (ctrl_vars[k]),
      .part_next (part_next[k]),
      .at_max    (at_max[k])
    );
  end

  // Sum tree: schedule time of the iteration that follows this fire.
  always_comb begin
    next_fire_time = offset_q;
    for (int k = 0; k < NUM_DIMS; k++) begin
      next_fire_time = next_fire_time + part_next[k];
    end
  end

`ifdef AFFINE_CTRL_ERR_EN
  logic viol;
  logic err_q;

  // A next fire time not strictly in the future can never be reached.
  assign viol          = fire && !last && (next_fire_time <= cycle_q);
  assign fire_time_sel = viol ? cycle_q + TIME_W'(1) : next_fire_time;
  assign err           = err_q;

  // Sticky violation flag, cleared only by rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      err_q <= 1'b0;
    end else if (viol) begin
      err_q <= 1'b1;
    end
  end
`else
  assign fire_time_sel = next_fire_time;
  assign err           = 1'b0;
`endif

  // Next-state logic; stall freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = empty ? ST_DONE : ST_DELAY;
        ST_DELAY: if (fire)  state_d = last ? ST_DONE : ST_RUN;
        ST_RUN:   if (last)  state_d = ST_DONE;
        ST_DONE:  if (start) state_d = empty ? ST_DONE : ST_DELAY;
                  else       state_d = ST_IDLE;
        default:             state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycle counter and scheduled fire time.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cycle_q     <= '0;
      fire_time_q <= '0;
    end else if (load) begin
      cycle_q     <= '0;
      fire_time_q <= cfg_offset;
    end else if (busy && !stall) begin
      cycle_q <= cycle_q + TIME_W'(1);
      if (fire && !last) begin
        fire_time_q <= fire_time_sel;
      end
    end
  end

  // Configuration latched at launch; flush keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      extent_q <= '0;
      stride_q <= '0;
      offset_q <= '0;
    end else if (load) begin
      extent_q <= cfg_extent;
      stride_q <= cfg_cycle_stride;
      offset_q <= cfg_offset;
    end
  end

endmodule
